// File: rtl/arb_pkg.sv
// Shared definitions for the RAM data-port arbiter: requester ids,
// ownership state encoding and default bus widths.
package arb_pkg;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_MW = DEF_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way grant pick: a lone requester always wins; a tie
// goes to requester 0 under fixed priority, otherwise to the id that was
// not granted last.
module arb_rr_pick #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant from the request pair and the last-granted id
  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (FIXED_PRIO != 0) gnt = 2'b01;
        else if (last)       gnt = 2'b01;
        else                 gnt = 2'b10;
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single RAM data port (a2/di2/do2/m2/we2).
// Requester 0 is the CPU load/store path, requester 1 the debug/loader
// master. Read data returns one cycle after the grant, tagged by rvalidN.
// Optional feature: define ARB_LOCK_EN to add lock0/lock1 ownership with a
// MAX_LOCK bound on consecutive locked grants.
module ram_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MW         = DEF_MW,
  parameter int FIXED_PRIO = 0
`ifdef ARB_LOCK_EN
  ,
  parameter int MAX_LOCK   = 8
`endif
) (
  input  logic          sys_clk,
  input  logic          sys_res,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [MW-1:0] mask0,
  input  logic [MW-1:0] mask1,
  input  logic          we0,
  input  logic          we1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
`ifdef ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  output logic [MW-1:0] ram_m,
  output logic          ram_we,
  input  logic [DW-1:0] ram_do
);

  logic       last;
  logic       rsp_valid;
  logic       rsp_id;
  logic [1:0] req_vec;
  logic [1:0] pick_req;
  logic [1:0] gnt_vec;
  logic       rd_gnt;

  // Requests are gated by reset so no grant can reach the RAM while held
  assign req_vec = {req1, req0} & {2{sys_res}};

`ifdef ARB_LOCK_EN
  arb_state_t state;
  arb_state_t state_nxt;
  logic [7:0] lock_cnt;
  logic [7:0] lock_cnt_nxt;
  logic       hold0;
  logic       hold1;

  // Ownership only masks the other side while the owner keeps both req and
  // lock up; once either drops, that cycle is arbitrated as from IDLE so the
  // other master is served without a bubble.
  assign hold0 = (state == OWN0) && req_vec[0] && lock0;
  assign hold1 = (state == OWN1) && req_vec[1] && lock1;

  // Mask the non-owner's request while ownership is held
  always_comb begin
    pick_req = req_vec;
    if (hold0)      pick_req = {1'b0, req_vec[0]};
    else if (hold1) pick_req = {req_vec[1], 1'b0};
  end

  // Ownership next-state and consecutive-grant counter
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    if (hold0 || hold1) begin
      // a held cycle always grants the owner; the count running out ends it
      lock_cnt_nxt = lock_cnt - 8'd1;
      if (lock_cnt_nxt == '0) state_nxt = IDLE;
    end else begin
      state_nxt    = IDLE;
      lock_cnt_nxt = '0;
      if (MAX_LOCK > 1) begin
        if (gnt_vec[0] && lock0) begin
          state_nxt    = OWN0;
          lock_cnt_nxt = 8'(MAX_LOCK - 1);
        end else if (gnt_vec[1] && lock1) begin
          state_nxt    = OWN1;
          lock_cnt_nxt = 8'(MAX_LOCK - 1);
        end
      end
    end
  end

  // Ownership state register
  always_ff @(posedge sys_clk or negedge sys_res) begin
    if (!sys_res) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end
`else
  assign pick_req = req_vec;
`endif

  arb_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req  (pick_req),
    .last (last),
    .gnt  (gnt_vec)
  );

  assign gnt0   = gnt_vec[0];
  assign gnt1   = gnt_vec[1];
  assign rd_gnt = (gnt_vec[0] && !we0) || (gnt_vec[1] && !we1);

  // Route the granted requester's fields to the RAM; idle port drives zeros
  always_comb begin
    ram_a  = '0;
    ram_di = '0;
    ram_m  = '0;
    ram_we = 1'b0;
    if (gnt_vec[0]) begin
      ram_a  = addr0;
      ram_di = wdata0;
      ram_m  = mask0;
      ram_we = we0;
    end else if (gnt_vec[1]) begin
      ram_a  = addr1;
      ram_di = wdata1;
      ram_m  = mask1;
      ram_we = we1;
    end
  end

  // Last-granted id and the one-cycle read response tag
  always_ff @(posedge sys_clk or negedge sys_res) begin
    if (!sys_res) begin
      last      <= REQ_DBG;
      rsp_valid <= 1'b0;
      rsp_id    <= REQ_CPU;
    end else begin
      if (|gnt_vec) last <= gnt_vec[1];
      rsp_valid <= rd_gnt;
      if (rd_gnt) rsp_id <= gnt_vec[1];
    end
  end

  assign rvalid0 = rsp_valid && (rsp_id == REQ_CPU);
  assign rvalid1 = rsp_valid && (rsp_id == REQ_DBG);
  assign rdata   = ram_do;

endmodule
